// File: rtl/onchip_mem_pkg.sv
// Shared definitions for blocks attached to the 4096 x 32 dual-port on-chip memory.
package onchip_mem_pkg;

  localparam int MEM_ADDR_W = 12;
  localparam int MEM_DATA_W = 32;

  // Every access on the read port is a full-word access
  localparam logic [3:0] BYTEEN_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry register FIFO carrying a data word plus an end-of-block flag.
// The head entry drives the outputs directly, so the payload is registered.
module stream_fifo2
  import onchip_mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_full,
  output logic              o_empty,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_data0;
  logic              r_last0;
  logic [DATA_W-1:0] r_data1;
  logic              r_last1;
  logic [1:0]        r_count;
  logic              w_pop;

  // A pop against an empty FIFO is meaningless and is ignored
  assign w_pop = i_pop && (r_count != 2'd0);

  // Entry 0 is the head; a pop shifts entry 1 forward
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data0 <= '0;
      r_last0 <= 1'b0;
      r_data1 <= '0;
      r_last1 <= 1'b0;
      r_count <= 2'd0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_data0 <= i_data;
            r_last0 <= i_last;
          end else begin
            r_data1 <= i_data;
            r_last1 <= i_last;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_data0 <= r_data1;
          r_last0 <= r_last1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_data0 <= r_data1;
            r_last0 <= r_last1;
            r_data1 <= i_data;
            r_last1 <= i_last;
          end else begin
            r_data0 <= i_data;
            r_last0 <= i_last;
          end
        end
        default: ;
      endcase
    end
  end

  // The producer's credit scheme must never push into a full FIFO
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(i_push && !w_pop && (r_count == 2'd2)));

  assign o_data  = r_data0;
  assign o_last  = r_last0;
  assign o_count = r_count;
  assign o_full  = (r_count == 2'd2);
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/onchip_stream_reader.sv
// Streaming read engine on the s2 port of the on-chip memory: fetches a block
// of consecutive words and presents them on a valid/ready stream, absorbing the
// one-cycle read latency and downstream backpressure in a two-entry FIFO.
module onchip_stream_reader
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic              r_inflight;
  logic              r_inflight_last;
  logic              r_busy;
  logic              r_done;

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [1:0]        w_fifo_count;
  logic              w_pop;
  logic [1:0]        w_occ;
  logic [2:0]        w_used;
  logic              w_issue;
  logic              w_drained;

  assign w_pop = out_valid && out_ready;

  // Slots committed after this cycle's pop: FIFO occupancy plus the word still
  // in the memory pipeline. Counting the pop keeps one issue per cycle under
  // continuous flow while still bounding the buffer at two words.
  assign w_occ   = w_fifo_full ? 2'd2 : (w_fifo_empty ? 2'd0 : 2'd1);
  assign w_used  = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == READ) && (r_remaining != '0) && (w_used < 3'd2);

  // Everything delivered once the last word leaves this cycle with nothing in flight
  assign w_drained = !r_inflight && (w_fifo_count == {1'b0, w_pop});

  // Transfer sequencing, address/issue counters and read-pipeline tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_remaining == REM_ONE);
      r_done          <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              r_addr      <= start_addr;
              r_remaining <= length;
              r_busy      <= 1'b1;
              r_state     <= READ;
            end else begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        READ: begin
          if (w_issue) begin
            r_addr      <= r_addr + ADDR_ONE;
            r_remaining <= r_remaining - REM_ONE;
            if (r_remaining == REM_ONE) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_drained) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  stream_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_data  (mem_readdata),
    .i_last  (r_inflight_last),
    .i_pop   (w_pop),
    .o_data  (out_data),
    .o_last  (out_last),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign out_valid      = !w_fifo_empty;
  assign busy           = r_busy;
  assign done           = r_done;
  assign mem_chipselect = w_issue;
  assign mem_address    = r_addr;
  assign mem_clken      = 1'b1;
  assign mem_write      = 1'b0;
  assign mem_byteenable = BYTEEN_ALL;
  assign mem_writedata  = '0;

endmodule

// File: tb/tb_onchip_stream_reader.sv
// Bench for onchip_stream_reader: memory model on s2, randomized backpressure,
// expected stream built as mem[(start_addr + i) mod 4096] for i < length.
module tb_onchip_stream_reader;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 4096;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_address;
  logic          mem_chipselect;
  logic          mem_clken;
  logic          mem_write;
  logic [3:0]    mem_byteenable;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  logic [DW-1:0] mem [DEPTH];

  int n_checks;
  int n_errors;

  onchip_stream_reader #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .start_addr     (start_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // s2 read port: one-cycle latency
  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= mem[mem_address];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one block. restart_cyc>0 injects a second start strobe in that cycle;
  // abort_after>=0 raises reset once that many words have been accepted.
  task automatic run_block(input int addr, input int len, input bit rand_ready,
                           input int restart_cyc, input int abort_after);
    logic [DW-1:0] exp_data[$];
    bit            exp_last[$];
    int            issued;
    int            accepted;
    int            done_cyc;
    int            first_cyc;
    int            budget;
    bit            aborted;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    for (int i = 0; i < len; i++) begin
      exp_data.push_back(mem[(addr + i) % DEPTH]);
      exp_last.push_back(i == len - 1);
    end
    issued     = 0;
    accepted   = 0;
    done_cyc   = -1;
    first_cyc  = -1;
    aborted    = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    budget     = rand_ready ? (6 * len + 40) : (len + 20);

    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = addr[AW-1:0];
    length     = len[AW:0];
    out_ready  = 1'b1;

    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        start_addr = AW'($urandom_range(0, DEPTH - 1));
        length     = (AW + 1)'(5);
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cyc == 1) check("busy_cycle1", busy, (len != 0));
      if (mem_chipselect) begin
        check("issue_in_range", (issued < len), 1);
        check("issue_addr", mem_address, (addr + issued) % DEPTH);
        check("credit", ((issued - accepted - int'(out_valid && out_ready)) < 2), 1);
        issued++;
      end
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_data.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          if (first_cyc < 0) first_cyc = cyc;
          check("data", out_data, exp_data.pop_front());
          check("last", out_last, exp_last.pop_front());
        end
        accepted++;
        if (abort_after >= 0 && accepted == abort_after) begin
          reset   = 1'b1;
          aborted = 1'b1;
          break;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (done) begin
        done_cyc = cyc;
        check("busy_at_done", busy, 0);
        break;
      end
    end

    start = 1'b0;
    if (abort_after >= 0) begin
      check("abort_reached", aborted, 1);
      return;
    end
    check("done_seen", (done_cyc > 0), 1);
    check("word_count", accepted, len);
    check("words_left", exp_data.size(), 0);
    if (!rand_ready) begin
      check("done_cycle", done_cyc, (len == 0) ? 1 : len + 3);
      if (len > 0) check("first_latency", first_cyc, 3);
    end
    @(posedge clk); #2;
    check("done_one_pulse", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  task automatic check_reset_values();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cs", mem_chipselect, 0);
    check("rst_addr", mem_address, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_data", out_data, 0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
    out_ready  = 1'b0;
    for (int k = 0; k < DEPTH; k++) mem[k] = k;

    repeat (3) @(posedge clk);
    #2;
    check_reset_values();
    check("tie_clken", mem_clken, 1);
    check("tie_write", mem_write, 0);
    check("tie_byteen", mem_byteenable, 4'hF);
    check("tie_wdata", mem_writedata, 0);
    reset = 1'b0;

    // Basic block on mem[k] = k: expect 0x10..0x13
    run_block(12'h010, 4, 1'b0, 0, -1);

    // Distinct random contents; low 12 bits still carry the address
    for (int k = 0; k < DEPTH; k++) mem[k] = ($urandom() << 12) | k;

    run_block(12'hFFE, 4, 1'b0, 0, -1);
    run_block(12'h000, 0, 1'b0, 0, -1);
    for (int t = 0; t < 3; t++) run_block($urandom_range(0, DEPTH - 1), 8, 1'b1, 0, -1);
    run_block(100, 16, 1'b0, 5, -1);
    run_block(12'h800, 4096, 1'b0, 0, -1);
    for (int t = 0; t < 4; t++)
      run_block($urandom_range(0, DEPTH - 1), $urandom_range(1, 40), 1'b1, 0, -1);

    // Abort after three words, then confirm silence and a clean restart
    run_block(12'h300, 10, 1'b0, 0, 3);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_reset_values();
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #2;
      check("quiet_valid", out_valid, 0);
      check("quiet_done", done, 0);
    end
    run_block(12'h123, 10, 1'b0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/onchip_stream_reader.md
# onchip_stream_reader

Streaming read engine on the second port (s2) of the 4096 x 32 dual-port on-chip memory. On a start command it fetches a block of consecutive 32-bit words and presents them on a valid/ready stream. It handles the memory's one-cycle read latency and downstream backpressure without losing words. Port s1 stays with the processor, which fills the buffer before starting the reader.

## Interface
Parameters:
- ADDR_W, 12, word-address width; memory depth is 2^ADDR_W
- DATA_W, 32, word width

Ports:
- clk  in  1  single clock, same clock as the memory's s2 port
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle command strobe; ignored while busy
- start_addr  in  ADDR_W  first word address
- length  in  ADDR_W+1  word count, 0..4096
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- mem_address  out  ADDR_W  to address2
- mem_chipselect  out  1  to chipselect2
- mem_clken  out  1  to clken2; tied 1
- mem_write  out  1  to write2; tied 0
- mem_byteenable  out  4  to byteenable2; tied 4'hF
- mem_writedata  out  DATA_W  to writedata2; tied 0
- mem_readdata  in  DATA_W  from readdata2; valid the cycle after the address is issued
- out_data  out  DATA_W  stream payload
- out_valid  out  1  payload valid
- out_ready  in  1  sink accepts when valid and ready
- out_last  out  1  marks the final word of the block

## Operation
- Reset values: busy=0, done=0, mem_chipselect=0, mem_address=0, out_valid=0, out_last=0, out_data=0. FIFO is emptied and the state is IDLE.
- FSM states:
  - IDLE: wait for start.
  - READ: issue reads.
  - DRAIN: all reads issued; empty the FIFO.
  - DONE: one cycle; done=1.
- IDLE -> READ: start=1 and length!=0. Latch the address counter (addr_q) from start_addr and the issue counter from length.
- IDLE -> DONE: start=1 and length=0. No memory access.
- READ: a read is issued in any cycle where remaining>0 and occupancy+inflight<2.
  - Issue means mem_chipselect=1 and mem_address=addr_q.
  - After an issue, addr_q increments modulo 2^ADDR_W (4095 wraps to 0) and remaining decrements.
- READ -> DRAIN when the last read issues.
- DRAIN -> DONE when the FIFO is empty and inflight=0.
- DONE -> IDLE unconditionally.
- inflight is a 1-bit flag: set on issue, cleared next cycle. When it is set, mem_readdata is pushed into the 2-entry output FIFO.
- The FIFO carries data plus a last bit. last=1 on the word whose issue had remaining==1.
- Push and pop in the same cycle are both legal; occupancy is unchanged.
- The credit rule guarantees the FIFO never overflows; an overflow is an assertion failure.
- out_data, out_valid and out_last come straight from the FIFO head registers.
- busy=1 in READ and DRAIN, 0 in IDLE and DONE.
- A start strobe during READ, DRAIN or DONE is dropped.
- reset mid-transfer aborts immediately on the next edge. The in-flight word is discarded, no done pulse is produced, and no out_valid appears after reset.

## Timing
- The start strobe is sampled at edge E0.
- Cycle 1 (after E0): first mem_chipselect=1, busy=1.
- Cycle 2: mem_readdata valid; the word is pushed at the end of the cycle.
- Cycle 3: first out_valid=1. First-word latency is 3 cycles.
- With out_ready held at 1, one word is issued and one delivered per cycle.
  - A block of N words has its last handshake in cycle N+2.
  - done pulses in cycle N+3; busy is low from cycle N+3.
- When out_ready deasserts:
  - Issue stops within one cycle.
  - At most 2 words are buffered.
  - Nothing is dropped or duplicated.
- out_data and out_last hold stable while out_valid=1 and out_ready=0.
- The earliest next start that is accepted is in the cycle after done.

## Structure
- Shared package, onchip_mem_pkg:
  - ADDR_W and DATA_W constants
  - FSM state enum {IDLE, READ, DRAIN, DONE}
  - the all-ones byteenable constant
- One natural sub-module: stream_fifo2, a 2-entry register FIFO with data+last, push/pop, and full/empty/count outputs. Reusable by a future s1-side writer.
- No memory instance inside this block. The top level connects the mem_* ports to the memory's s2 port.

## Test plan
- Basic block: memory preloaded with mem[k]=k. start_addr=0x010, length=4, out_ready=1 -> out_data 0x10..0x13 in cycles 3..6, out_last only on 0x13, done in cycle 7.
- Wrap-around: start_addr=0xFFE, length=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001; data mem[0xFFE], mem[0xFFF], mem[0], mem[1].
- Backpressure: length=8, out_ready toggles 1,0,0,1,... randomly -> all 8 words in order, no duplicates, mem_chipselect never high when occupancy+inflight=2, payload stable while stalled.
- Zero length and start while busy:
  - length=0 -> done in cycle 1, no chipselect, no out_valid.
  - A second start during a 16-word transfer -> ignored; exactly 16 words delivered.
- Full memory: length=4096, start_addr=0x800 -> 4096 words, 1 per cycle with out_ready=1, done in cycle 4099, address sequence wraps once.
- Reset mid-operation: reset asserted for 1 cycle after 3 of 10 words are delivered -> all outputs at reset values next cycle, no further out_valid or done. A new start then runs a clean transfer.
